// File: rtl/calc_req_scheduler_if.sv
// calc_req_scheduler_if: response channel of the shared calc datapath.
// Valid/ready handshake carrying the requester id and the signed result.
interface calc_req_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int IDW   = 2
);
    logic             resp_valid;
    logic             resp_ready;
    logic [IDW-1:0]   resp_id;
    logic [WIDTH-1:0] resp_data;

    modport master (
        output resp_valid,
        output resp_id,
        output resp_data,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_id,
        input  resp_data,
        output resp_ready
    );
endinterface

// File: rtl/calc_req_scheduler.sv
// calc_req_scheduler: round-robin sharing of a fixed-latency datapath.
// Define CALC_SCHED_STATS_EN to add the stall_cnt / issue_cnt outputs.
module calc_req_scheduler #(
    parameter int WIDTH      = 32,
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*WIDTH-1:0] req_c,
    input  logic [NUM_REQ*WIDTH-1:0] req_d,
    output logic                     dp_valid,
    output logic [WIDTH-1:0]         dp_a,
    output logic [WIDTH-1:0]         dp_b,
    output logic [WIDTH-1:0]         dp_c,
    output logic [WIDTH-1:0]         dp_d,
    input  logic [WIDTH-1:0]         dp_q,
    calc_req_scheduler_if.master     resp
`ifdef CALC_SCHED_STATS_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              issue_cnt
`endif
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic             can_issue;
    logic             xfer;
    int               scan;

    logic [IDW-1:0]   dp_id;
    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]   tag_id [LATENCY];

    logic [CW-1:0]    in_flight;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      credit_used;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [IDW-1:0]   mem_id   [FIFO_DEPTH];
    logic             push;
    logic             pop;

    // The issue register holds the youngest tag, so it counts as in flight.
    always_comb begin
        in_flight = CW'(dp_valid);
        for (int i = 0; i < LATENCY; i++) begin
            in_flight = in_flight + CW'(tag_v[i]);
        end
    end

    assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
    assign can_issue   = credit_used < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            if (!grant_found && req_valid[scan]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(scan);
            end
        end
    end

    assign xfer      = grant_found && can_issue && rst_n;
    assign req_ready = xfer ? (ONE_HOT0 << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            dp_valid <= 1'b0;
            dp_id    <= '0;
            dp_a     <= '0;
            dp_b     <= '0;
            dp_c     <= '0;
            dp_d     <= '0;
        end else begin
            dp_valid <= xfer;
            if (xfer) begin
                dp_id <= grant_idx;
                dp_a  <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                dp_b  <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                dp_c  <= req_c[int'(grant_idx)*WIDTH +: WIDTH];
                dp_d  <= req_d[int'(grant_idx)*WIDTH +: WIDTH];
                rr_ptr <= (grant_idx == IDW'(NUM_REQ-1)) ?
                          '0 : grant_idx + 1'b1;
            end
        end
    end

    // Tail of the tag pipe lines up with dp_q of the same issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= dp_valid;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= dp_id;
        for (int i = 1; i < LATENCY; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

    assign push = tag_v[LATENCY-1];
    assign pop  = resp.resp_valid && resp.resp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= dp_q;
            mem_id[wr_ptr]   <= tag_id[LATENCY-1];
        end
    end

    assign resp.resp_valid = (fifo_count != '0);
    assign resp.resp_id    = resp.resp_valid ? mem_id[rd_ptr]   : '0;
    assign resp.resp_data  = resp.resp_valid ? mem_data[rd_ptr] : '0;

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_count == CW'(FIFO_DEPTH)));

`ifdef CALC_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (|req_valid && !can_issue && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (xfer) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
